i2s_stream_tx: RTL

Serializing I2S transmitter that feeds the LED-panel receive path. It accepts parallel left/right sample words over a valid/ready handshake and emits them MSB-first as standard I2S frames, with word-select leading data by one bit. It sits upstream of the panel receiver and shares its bit clock, so a single FPGA can drive a chain of panels or loop back onto its own receiver for test.

---
 rtl/i2s_stream_tx_pkg.sv | 16 +
 rtl/i2s_stream_tx_if.sv | 16 +
 rtl/i2s_stream_tx.sv | 100 ++++++++++
 3 files changed

// File: rtl/i2s_stream_tx_pkg.sv
// i2s_pkg: shared types and helpers for the I2S transmit path and its receiver.
//   state_t        - transmitter FSM states
//   WORD_W_DEFAULT - default slot width in bits
//   ws_at(p, w)    - word-select level while frame bit p of a w-bit-slot frame is shifted
package i2s_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int WORD_W_DEFAULT = 16;

    // WS goes high one bit before the right MSB and drops one bit before the next left MSB
    function automatic logic ws_at(input int p, input int w);
        return (p >= w - 1) && (p <= 2 * w - 2);
    endfunction

endpackage

// File: rtl/i2s_stream_tx_if.sv
// i2s_stream_tx_if: valid/ready sample-pair stream feeding the I2S transmitter.
//   s_valid - source has a left/right pair
//   s_ready - sink can take the pair this cycle
//   s_left  - left slot word (WS=0)
//   s_right - right slot word (WS=1)
interface i2s_stream_tx_if #(
    parameter int WORD_W = i2s_pkg::WORD_W_DEFAULT
);
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_left;
    logic [WORD_W-1:0] s_right;

    modport master(output s_valid, s_left, s_right, input s_ready);
    modport slave(input s_valid, s_left, s_right, output s_ready);
endinterface

// File: rtl/i2s_stream_tx.sv
// i2s_stream_tx: serializes left/right sample pairs into MSB-first I2S frames.
//   i2s_clk     - bit clock, all state on its rising edge
//   rst_n       - asynchronous active-low reset
//   en          - transmit enable, acted on only at frame boundaries
//   s           - sample-pair stream (slave side)
//   i2s_data    - registered serial data
//   i2s_ws      - registered word select, leads each slot's MSB by one bit
//   frame_start - pulses in the cycle the shifter loads
//   underrun    - pulses when a running frame boundary finds no pair waiting
module i2s_stream_tx
    import i2s_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT
) (
    input  logic           i2s_clk,
    input  logic           rst_n,
    input  logic           en,
    i2s_stream_tx_if.slave s,
    output logic           i2s_data,
    output logic           i2s_ws,
    output logic           frame_start,
    output logic           underrun
);

    localparam int FW = 2 * WORD_W;
    localparam int CW = $clog2(FW);
    localparam logic [CW-1:0] LAST = CW'(FW - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FW-1:0]     sh_q, sh_d;
    logic [WORD_W-1:0] hold_l_q, hold_r_q;
    logic              hold_full_q, hold_full_d;
    logic              data_q, data_d;
    logic              ws_q, ws_d;
    logic              load;
    logic              xfer;

    // A load frees the holding register in the same cycle, so a new pair can land alongside it
    assign s.s_ready   = !hold_full_q || load;
    assign xfer        = s.s_valid && (!hold_full_q || load);
    assign hold_full_d = xfer || (hold_full_q && !load);
    assign frame_start = load;
    assign i2s_data    = data_q;
    assign i2s_ws      = ws_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        sh_d     = sh_q;
        data_d   = 1'b0;
        ws_d     = 1'b0;
        load     = 1'b0;
        underrun = 1'b0;
        if (state_q == IDLE) begin
            load    = en && hold_full_q;
            state_d = load ? RUN : IDLE;
        end else begin
            data_d = sh_q[FW-1];
            ws_d   = ws_at(int'(cnt_q), WORD_W);
            sh_d   = sh_q << 1;
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d  = en ? RUN : IDLE;
                load     = en && hold_full_q;
                underrun = en && !hold_full_q;
                // An underrun frame is sent as silence while keeping the WS cadence
                if (underrun)
                    sh_d = '0;
            end
        end
        if (load)
            sh_d = {hold_l_q, hold_r_q};
    end

    always_ff @(posedge i2s_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            hold_full_q <= 1'b0;
            data_q      <= 1'b0;
            ws_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            hold_full_q <= hold_full_d;
            data_q      <= data_d;
            ws_q        <= ws_d;
            if (xfer) begin
                hold_l_q <= s.s_left;
                hold_r_q <= s.s_right;
            end
        end
    end

endmodule
